// File: rtl/agc_timepulse_gen.sv
// agc_timepulse_gen: parametrised AGC phase/timepulse generator with monitor
// stop/single-step, GOJAM restart sequencing, standby gating and a free-running
// scaler. Define AGC_TIMEPULSE_MCT_COUNT_EN to add the 32-bit MCT_COUNT output.
module agc_timepulse_gen #(
    parameter int unsigned PHASES    = 4,
    parameter int unsigned NUM_T     = 12,
    parameter int unsigned GOJAM_LEN = 8,
    parameter int unsigned SCALER_W  = 17
) (
    input  logic                     CLOCK,
    input  logic                     SIM_RST,
    input  logic                     MSTP,
    input  logic                     MSTRTP,
    input  logic                     STRT1,
    input  logic                     STRT2,
    input  logic                     ALARM,
    input  logic                     SBY,
    output logic [PHASES-1:0]        PHS,
    output logic [NUM_T-1:0]         T,
    output logic [$clog2(NUM_T)-1:0] T_IDX,
    output logic                     MCT_END,
    output logic                     STOP,
    output logic                     GOJAM,
    output logic [SCALER_W-1:0]      FS,
    output logic                     FS_TICK
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
    ,
    output logic [31:0]              MCT_COUNT
`endif
);

    localparam int unsigned PW    = $clog2(PHASES);
    localparam int unsigned TW    = $clog2(NUM_T);
    localparam int unsigned PRE_N = PHASES * NUM_T;
    localparam int unsigned PRE_W = $clog2(PRE_N);
    localparam int unsigned GJ_W  = $clog2(GOJAM_LEN + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STOPPED = 2'd1,
        ST_STANDBY = 2'd2
    } run_state_t;

    run_state_t      st;
    logic [PW-1:0]   ph;
    logic [PW-1:0]   ph_adv;
    logic [TW-1:0]   t;
    logic [TW-1:0]   t_adv;
    logic            ph_last;
    logic            mct_wrap;
    logic            end_adv;
    logic            mstrtp_q;
    logic            sby_q;
    logic            mstrtp_rise;
    logic            sby_fall;
    logic            trig;
    logic [PRE_W-1:0] pre;
    logic [GJ_W-1:0] gj_cnt;

    // Next position in the MCT, edge detects and the GOJAM trigger (SBY dominates in standby)
    always_comb begin
        ph_last  = (ph == PW'(PHASES - 1));
        mct_wrap = ph_last && (t == TW'(NUM_T - 1));
        ph_adv   = ph_last ? '0 : ph + PW'(1);
        if (!ph_last) begin
            t_adv = t;
        end else if (t == TW'(NUM_T - 1)) begin
            t_adv = '0;
        end else begin
            t_adv = t + TW'(1);
        end
        end_adv     = (ph_adv == PW'(PHASES - 1)) && (t_adv == TW'(NUM_T - 1));
        mstrtp_rise = MSTRTP && !mstrtp_q;
        sby_fall    = !SBY && sby_q;
        trig        = (st == ST_STANDBY) ? sby_fall : (STRT1 || STRT2 || ALARM);
    end

    // Run-state FSM with registered phase/timepulse decodes
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            st      <= ST_RUN;
            ph      <= '0;
            t       <= '0;
            PHS     <= PHASES'(1);
            T       <= NUM_T'(1);
            T_IDX   <= '0;
            MCT_END <= 1'b0;
            STOP    <= 1'b0;
        end else if (trig) begin
            st      <= ST_RUN;
            ph      <= '0;
            t       <= '0;
            PHS     <= PHASES'(1);
            T       <= NUM_T'(1);
            T_IDX   <= '0;
            MCT_END <= 1'b0;
            STOP    <= 1'b0;
        end else begin
            case (st)
                ST_RUN: begin
                    ph      <= ph_adv;
                    t       <= t_adv;
                    T_IDX   <= t_adv;
                    PHS     <= PHASES'(1) << ph_adv;
                    T       <= NUM_T'(1) << t_adv;
                    MCT_END <= end_adv;
                    // At the MCT wrap standby wins over a monitor stop
                    if (mct_wrap && SBY) begin
                        st  <= ST_STANDBY;
                        PHS <= '0;
                        T   <= '0;
                    end else if (mct_wrap && MSTP) begin
                        st   <= ST_STOPPED;
                        PHS  <= '0;
                        T    <= '0;
                        STOP <= 1'b1;
                    end
                end
                ST_STOPPED: begin
                    if (SBY) begin
                        st   <= ST_STANDBY;
                        STOP <= 1'b0;
                    end else if (mstrtp_rise) begin
                        st   <= ST_RUN;
                        STOP <= 1'b0;
                        PHS  <= PHASES'(1);
                        T    <= NUM_T'(1);
                    end
                end
                default: begin
                    // Standby holds; only an SBY fall (handled as a trigger) leaves it
                    st <= st;
                end
            endcase
        end
    end

    // Input edge registers and the GOJAM hold counter
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            mstrtp_q <= 1'b0;
            sby_q    <= 1'b0;
            gj_cnt   <= GJ_W'(GOJAM_LEN);
            GOJAM    <= 1'b1;
        end else begin
            mstrtp_q <= MSTRTP;
            sby_q    <= SBY;
            if (trig) begin
                gj_cnt <= GJ_W'(GOJAM_LEN);
                GOJAM  <= 1'b1;
            end else if (gj_cnt != '0) begin
                gj_cnt <= gj_cnt - GJ_W'(1);
                GOJAM  <= (gj_cnt != GJ_W'(1));
            end else begin
                GOJAM <= 1'b0;
            end
        end
    end

    // Free-running prescaler and scaler, independent of run state and GOJAM
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            pre     <= '0;
            FS      <= '0;
            FS_TICK <= 1'b0;
        end else if (pre == PRE_W'(PRE_N - 1)) begin
            pre     <= '0;
            FS      <= FS + SCALER_W'(1);
            FS_TICK <= 1'b1;
        end else begin
            pre     <= pre + PRE_W'(1);
            FS_TICK <= 1'b0;
        end
    end

`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
    // Count completed MCTs in RUN; a GOJAM trigger clears the count
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            MCT_COUNT <= '0;
        end else if (trig) begin
            MCT_COUNT <= '0;
        end else if ((st == ST_RUN) && MCT_END) begin
            MCT_COUNT <= MCT_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Scoreboard bench for agc_timepulse_gen: directed stimulus queues expected
// per-cycle values; a negedge monitor pops and compares them.
module tb_agc_timepulse_gen;

    typedef enum int {
        S_PHS, S_T, S_T_IDX, S_MCT_END, S_STOP, S_GOJAM,
        S_FS, S_FS_TICK, S_FS2, S_FS_TICK2, S_MCT_COUNT
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        SIM_RST, MSTP, MSTRTP, STRT1, STRT2, ALARM, SBY;
    logic [3:0]  PHS;
    logic [11:0] T;
    logic [3:0]  T_IDX;
    logic        MCT_END, STOP, GOJAM, FS_TICK;
    logic [16:0] FS;
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
    logic [31:0] MCT_COUNT;
    logic [31:0] mct_count2;
`endif
    logic [1:0]  phs2, t2;
    logic [0:0]  t_idx2;
    logic        mct_end2, stop2, gojam2, fs_tick2;
    logic [2:0]  fs2;

    exp_t sb[$];
    int   cyc     = 0;
    int   r0      = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    agc_timepulse_gen dut (
        .CLOCK(CLOCK), .SIM_RST(SIM_RST), .MSTP(MSTP), .MSTRTP(MSTRTP),
        .STRT1(STRT1), .STRT2(STRT2), .ALARM(ALARM), .SBY(SBY),
        .PHS(PHS), .T(T), .T_IDX(T_IDX), .MCT_END(MCT_END), .STOP(STOP),
        .GOJAM(GOJAM), .FS(FS), .FS_TICK(FS_TICK)
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
        , .MCT_COUNT(MCT_COUNT)
`endif
    );

    agc_timepulse_gen #(.PHASES(2), .NUM_T(2), .GOJAM_LEN(8), .SCALER_W(3)) dut2 (
        .CLOCK(CLOCK), .SIM_RST(SIM_RST), .MSTP(MSTP), .MSTRTP(MSTRTP),
        .STRT1(STRT1), .STRT2(STRT2), .ALARM(ALARM), .SBY(SBY),
        .PHS(phs2), .T(t2), .T_IDX(t_idx2), .MCT_END(mct_end2), .STOP(stop2),
        .GOJAM(gojam2), .FS(fs2), .FS_TICK(fs_tick2)
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
        , .MCT_COUNT(mct_count2)
`endif
    );

    // Queue an expectation for cycle r0+k, kept sorted by cycle
    task automatic ex(input int k, input sig_e s, input int v);
        exp_t e;
        int   i;
        e.cyc = r0 + k;
        e.sig = s;
        e.val = 32'(v);
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > e.cyc) i--;
        sb.insert(i, e);
    endtask

    task automatic ex_cnt(input int k, input int v);
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
        ex(k, S_MCT_COUNT, v);
`else
        if (k < 0 || v < 0) $display("note: negative count expectation ignored");
`endif
    endtask

    task automatic goto_k(input int k);
        while (cyc < r0 + k) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    function automatic logic [31:0] actual(input sig_e s);
        case (s)
            S_PHS:      return 32'(PHS);
            S_T:        return 32'(T);
            S_T_IDX:    return 32'(T_IDX);
            S_MCT_END:  return 32'(MCT_END);
            S_STOP:     return 32'(STOP);
            S_GOJAM:    return 32'(GOJAM);
            S_FS:       return 32'(FS);
            S_FS_TICK:  return 32'(FS_TICK);
            S_FS2:      return 32'(fs2);
            S_FS_TICK2: return 32'(fs_tick2);
`ifdef AGC_TIMEPULSE_MCT_COUNT_EN
            S_MCT_COUNT: return MCT_COUNT;
`endif
            default:    return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle
    always @(negedge CLOCK) begin : monitor
        exp_t        e;
        sig_e        s;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            s = e.sig;
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s k=%0d not sampled in time, expected=0x%0h", s.name(), e.cyc - r0, e.val);
            end else begin
                a = actual(s);
                if (a !== e.val) begin
                    n_fail++;
                    $display("FAIL %s k=%0d actual=0x%0h expected=0x%0h", s.name(), e.cyc - r0, a, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        sig_e s;
        SIM_RST = 1'b1; MSTP = 1'b0; MSTRTP = 1'b0; STRT1 = 1'b0;
        STRT2 = 1'b0; ALARM = 1'b0; SBY = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        SIM_RST = 1'b0;
        r0 = cyc;

        // Free run after reset: reset state, phase/timepulse sequence, GOJAM length, scalers
        ex(0, S_PHS, 1); ex(0, S_T, 1); ex(0, S_T_IDX, 0); ex(0, S_GOJAM, 1);
        ex(0, S_STOP, 0); ex(0, S_MCT_END, 0); ex(0, S_FS, 0); ex(0, S_FS_TICK, 0);
        ex(0, S_FS2, 0); ex(0, S_FS_TICK2, 0);
        ex(1, S_PHS, 2); ex(2, S_PHS, 4); ex(3, S_PHS, 8); ex(3, S_T, 1);
        ex(4, S_PHS, 1); ex(4, S_T, 2); ex(4, S_T_IDX, 1);
        ex(4, S_FS2, 1); ex(4, S_FS_TICK2, 1); ex(5, S_FS2, 1); ex(5, S_FS_TICK2, 0);
        ex(7, S_GOJAM, 1); ex(8, S_GOJAM, 0);
        ex(27, S_PHS, 8); ex(27, S_T, 'h40);
        ex(28, S_FS2, 7); ex(31, S_FS2, 7); ex(32, S_FS2, 0); ex(32, S_FS_TICK2, 1);
        ex(36, S_FS2, 1);
        ex(44, S_T, 'h800); ex(44, S_T_IDX, 11);
        ex(46, S_MCT_END, 0); ex(47, S_MCT_END, 1); ex(47, S_FS, 0); ex(47, S_FS_TICK, 0);
        ex(48, S_T, 1); ex(48, S_PHS, 1); ex(48, S_MCT_END, 0); ex(48, S_FS, 1); ex(48, S_FS_TICK, 1);
        ex(49, S_FS_TICK, 0); ex(95, S_MCT_END, 1);
        ex_cnt(48, 1); ex_cnt(96, 2);
        goto_k(96);

        // Monitor stop, single MCT step, level MSTRTP ignored, free run, MSTRTP in RUN ignored
        ex(143, S_MCT_END, 1); ex(143, S_STOP, 0);
        ex(144, S_STOP, 1); ex(144, S_PHS, 0); ex(144, S_T, 0); ex(144, S_MCT_END, 0);
        ex(144, S_T_IDX, 0); ex(144, S_FS, 3); ex(144, S_FS_TICK, 1);
        ex(150, S_STOP, 1); ex(150, S_T, 0);
        ex(151, S_STOP, 0); ex(151, S_PHS, 1); ex(151, S_T, 1);
        ex(198, S_MCT_END, 1); ex(198, S_T, 'h800);
        ex(199, S_STOP, 1); ex(199, S_T, 0);
        ex(205, S_STOP, 1); ex(205, S_T, 0);
        ex(208, S_STOP, 0); ex(208, S_T, 1);
        ex(231, S_PHS, 8); ex(231, S_T, 'h20);
        ex(255, S_MCT_END, 1);
        ex(256, S_STOP, 0); ex(256, S_PHS, 1); ex(256, S_T, 1); ex(260, S_T, 2);
        ex_cnt(144, 3); ex_cnt(150, 3); ex_cnt(199, 4); ex_cnt(205, 4); ex_cnt(256, 5);
        goto_k(100); MSTP = 1'b1;
        goto_k(150); MSTRTP = 1'b1;
        goto_k(205); MSTRTP = 1'b0; MSTP = 1'b0;
        goto_k(207); MSTRTP = 1'b1;
        goto_k(209); MSTRTP = 1'b0;
        goto_k(230); MSTRTP = 1'b1;
        goto_k(231); MSTRTP = 1'b0;

        // STRT1 at T07 phase 3, STRT2 retrigger at gj_cnt=3
        ex(283, S_PHS, 8); ex(283, S_T, 'h40);
        ex(284, S_PHS, 1); ex(284, S_T, 1); ex(284, S_GOJAM, 1); ex(284, S_T_IDX, 0);
        ex(289, S_GOJAM, 1); ex(289, S_PHS, 2); ex(289, S_T, 2);
        ex(290, S_PHS, 1); ex(290, S_T, 1); ex(290, S_GOJAM, 1);
        ex(292, S_GOJAM, 1); ex(297, S_GOJAM, 1); ex(298, S_GOJAM, 0);
        ex_cnt(283, 5); ex_cnt(284, 0);
        goto_k(283); STRT1 = 1'b1;
        goto_k(284); STRT1 = 1'b0;
        goto_k(289); STRT2 = 1'b1;
        goto_k(290); STRT2 = 1'b0;

        // Standby mid-MCT, STRT1 ignored in standby, SBY fall restarts with GOJAM
        ex(334, S_T, 'h800); ex(337, S_MCT_END, 1);
        ex(338, S_T, 0); ex(338, S_PHS, 0); ex(338, S_STOP, 0); ex(338, S_MCT_END, 0); ex(338, S_FS, 7);
        ex(361, S_T, 0); ex(361, S_GOJAM, 0); ex(361, S_STOP, 0);
        ex(384, S_FS, 8); ex(384, S_FS_TICK, 1); ex(384, S_T, 0); ex(390, S_T, 0);
        ex(391, S_T, 1); ex(391, S_PHS, 1); ex(391, S_GOJAM, 1); ex(391, S_STOP, 0);
        ex(398, S_GOJAM, 1); ex(399, S_GOJAM, 0);
        ex_cnt(338, 1); ex_cnt(361, 1); ex_cnt(391, 0);
        goto_k(300); SBY = 1'b1;
        goto_k(360); STRT1 = 1'b1;
        goto_k(361); STRT1 = 1'b0;
        goto_k(390); SBY = 1'b0;

        // SBY while stopped goes straight to standby; ALARM while stopped restarts
        ex(438, S_MCT_END, 1); ex(439, S_STOP, 1); ex(439, S_T, 0); ex(442, S_STOP, 1);
        ex(443, S_STOP, 0); ex(443, S_T, 0); ex(443, S_PHS, 0); ex(443, S_GOJAM, 0);
        ex(445, S_STOP, 0);
        ex(446, S_GOJAM, 1); ex(446, S_T, 1); ex(446, S_STOP, 0);
        ex(493, S_MCT_END, 1); ex(494, S_STOP, 1); ex(494, S_T, 0); ex(500, S_STOP, 1);
        ex(501, S_STOP, 0); ex(501, S_T, 1); ex(501, S_PHS, 1); ex(501, S_GOJAM, 1); ex(501, S_FS, 10);
        ex(528, S_FS, 11); ex(528, S_FS_TICK, 1);
        ex_cnt(439, 1); ex_cnt(445, 1); ex_cnt(446, 0); ex_cnt(494, 1); ex_cnt(500, 1); ex_cnt(501, 0);
        goto_k(400); MSTP = 1'b1;
        goto_k(442); SBY = 1'b1;
        goto_k(445); SBY = 1'b0;
        goto_k(500); ALARM = 1'b1;
        goto_k(501); ALARM = 1'b0; MSTP = 1'b0;

        goto_k(532);
        repeat (2) @(posedge CLOCK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            s = e.sig;
            n_tests++;
            n_fail++;
            $display("FAIL %s k=%0d never compared, expected=0x%0h", s.name(), e.cyc - r0, e.val);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
